// File: rtl/mem_stage.sv
// Memory-access stage of the five-stage pipeline: issues data-cache requests,
// stalls upstream until the cache completes, and holds the MEM/WB register.
module mem_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RTD_ADDR,
  input  logic [31:0]      ALU_Res,
  input  logic [31:0]      RT_data,
  input  logic [31:0]      PC_plus_4,
  input  logic             RegWrite,
  input  logic             MemtoReg,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             isJAL,
  output logic             DCACHE_ren,
  output logic             DCACHE_wen,
  output logic [29:0]      DCACHE_addr,
  output logic [31:0]      DCACHE_wdata,
  input  logic [31:0]      DCACHE_rdata,
  input  logic             DCACHE_stall,
  output logic             MEM_stall,
  output logic [4:0]       WB_addr,
  output logic [31:0]      WB_data,
  output logic             WB_RegWrite,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             err_rw,
  output logic             err_misalign,
  output logic             stateDbg
);

  // Handshake: the request (ren/wen) is held while DCACHE_stall is high;
  // the access completes in the first cycle the request is seen with
  // DCACHE_stall low. Upstream is frozen by MEM_stall in the meantime.
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state, nextState;
  logic        acc;
  logic        complete;
  logic [31:0] wbValue;

  assign acc          = MemRead | MemWrite;
  assign DCACHE_wen   = MemWrite;
  assign DCACHE_ren   = MemRead & ~MemWrite;
  assign DCACHE_addr  = ALU_Res[31:2];
  assign DCACHE_wdata = RT_data;
  assign MEM_stall    = acc & DCACHE_stall;
  assign stateDbg     = state;

  // A request vanishing while BUSY is illegal; it is dropped without write-back.
  assign complete = ~MEM_stall & ~((state == BUSY) & ~acc);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (acc && DCACHE_stall) nextState = BUSY;
      BUSY:    if (!acc || !DCACHE_stall) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    wbValue = ALU_Res;
    if (isJAL)         wbValue = PC_plus_4;
    else if (MemtoReg) wbValue = DCACHE_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      WB_addr      <= '0;
      WB_data      <= '0;
      WB_RegWrite  <= 1'b0;
      stall_cycles <= '0;
      err_rw       <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      state <= nextState;
      if (complete) begin
        WB_addr     <= RTD_ADDR;
        WB_data     <= wbValue;
        WB_RegWrite <= RegWrite;
      end else begin
        WB_RegWrite <= 1'b0;
      end
      if (MEM_stall && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
      if (MemRead && MemWrite) err_rw <= 1'b1;
      if (acc && ALU_Res[1:0] != 2'b00) err_misalign <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a cycle-level
// reference model of the stage's write-back, stall and error rules.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  RTD_ADDR;
  logic [31:0] ALU_Res, RT_data, PC_plus_4, DCACHE_rdata;
  logic        RegWrite, MemtoReg, MemRead, MemWrite, isJAL, DCACHE_stall;
  logic        DCACHE_ren, DCACHE_wen, MEM_stall, WB_RegWrite;
  logic [29:0] DCACHE_addr;
  logic [31:0] DCACHE_wdata, WB_data;
  logic [4:0]  WB_addr;
  logic [15:0] stall_cycles;
  logic        err_rw, err_misalign, stateDbg;
  // narrow-counter instance, shares all inputs
  logic        s_ren, s_wen, s_stall, s_we, s_rw, s_mis, s_state;
  logic [29:0] s_addr;
  logic [31:0] s_wdata, s_data;
  logic [4:0]  s_waddr;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  mem_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .RTD_ADDR(RTD_ADDR), .ALU_Res(ALU_Res), .RT_data(RT_data),
    .PC_plus_4(PC_plus_4), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .isJAL(isJAL), .DCACHE_ren(DCACHE_ren), .DCACHE_wen(DCACHE_wen),
    .DCACHE_addr(DCACHE_addr), .DCACHE_wdata(DCACHE_wdata), .DCACHE_rdata(DCACHE_rdata),
    .DCACHE_stall(DCACHE_stall), .MEM_stall(MEM_stall), .WB_addr(WB_addr), .WB_data(WB_data),
    .WB_RegWrite(WB_RegWrite), .stall_cycles(stall_cycles), .err_rw(err_rw),
    .err_misalign(err_misalign), .stateDbg(stateDbg)
  );

  mem_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .RTD_ADDR(RTD_ADDR), .ALU_Res(ALU_Res), .RT_data(RT_data),
    .PC_plus_4(PC_plus_4), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .isJAL(isJAL), .DCACHE_ren(s_ren), .DCACHE_wen(s_wen),
    .DCACHE_addr(s_addr), .DCACHE_wdata(s_wdata), .DCACHE_rdata(DCACHE_rdata),
    .DCACHE_stall(DCACHE_stall), .MEM_stall(s_stall), .WB_addr(s_waddr), .WB_data(s_data),
    .WB_RegWrite(s_we), .stall_cycles(s_cnt), .err_rw(s_rw),
    .err_misalign(s_mis), .stateDbg(s_state)
  );

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [31:0] exp_q[$];
  logic [4:0]  mAddr;
  logic [31:0] mData;
  logic        mWe, mRw, mMis, mBusy;
  int          mCnt, mCnt2;

  task automatic modelEdge();
    logic        acc, ms;
    logic [31:0] val;
    if (rst) begin
      mAddr = 0; mData = 0; mWe = 0; mRw = 0; mMis = 0; mBusy = 0;
      mCnt = 0; mCnt2 = 0;
      exp_q.delete();
    end else begin
      acc = MemRead | MemWrite;
      ms  = acc & DCACHE_stall;
      if (ms) begin
        mWe = 0;
        if (mCnt < 65535) mCnt++;
        if (mCnt2 < 3) mCnt2++;
      end else begin
        val = isJAL ? PC_plus_4 : (MemtoReg ? DCACHE_rdata : ALU_Res);
        mAddr = RTD_ADDR; mData = val; mWe = RegWrite;
        exp_q.push_back(val);
      end
      if (MemRead && MemWrite) mRw = 1;
      if (acc && ALU_Res[1:0] != 2'b00) mMis = 1;
      mBusy = ms;
    end
  endtask

  // Called at a falling edge with inputs already driven: checks the
  // combinational outputs, advances one rising edge, checks registered state.
  task automatic tick();
    #1;
    check("ren",   DCACHE_ren,   MemRead && !MemWrite);
    check("wen",   DCACHE_wen,   MemWrite);
    check("addr",  DCACHE_addr,  ALU_Res >> 2);
    check("wdata", DCACHE_wdata, RT_data);
    check("stall", MEM_stall,    (MemRead || MemWrite) && DCACHE_stall);
    check("state", stateDbg,     mBusy);
    @(posedge clk);
    modelEdge();
    #1;
    check("wb_we",   WB_RegWrite,  mWe);
    check("wb_addr", WB_addr,      mAddr);
    check("wb_data", WB_data,      mData);
    check("cnt",     stall_cycles, mCnt);
    check("cnt2",    s_cnt,        mCnt2);
    check("err_rw",  err_rw,       mRw);
    check("err_mis", err_misalign, mMis);
    if (exp_q.size() > 0) check("wb_q", WB_data, exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic setIns(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rt,
                        input logic [31:0] pc, input logic rw, input logic m2r,
                        input logic mr, input logic mw, input logic jal);
    RTD_ADDR = rd; ALU_Res = alu; RT_data = rt; PC_plus_4 = pc;
    RegWrite = rw; MemtoReg = m2r; MemRead = mr; MemWrite = mw; isJAL = jal;
  endtask

  task automatic clearIns();
    setIns(0, 0, 0, 0, 0, 0, 0, 0, 0);
    DCACHE_stall = 0;
  endtask

  initial begin
    rst = 1;
    clearIns();
    DCACHE_rdata = 0;
    mBusy = 0;
    @(negedge clk);
    tick();
    check("rst_wb_data", WB_data, 0);
    check("rst_cnt", stall_cycles, 0);
    rst = 0;

    // ALU op
    setIns(5, 32'h1234, 0, 0, 1, 0, 0, 0, 0);
    tick();
    check("alu_we", WB_RegWrite, 1);
    check("alu_addr", WB_addr, 5);
    check("alu_data", WB_data, 32'h1234);

    // load with three stall cycles
    setIns(3, 32'h100, 0, 0, 1, 1, 1, 0, 0);
    DCACHE_stall = 1;
    for (int i = 0; i < 3; i++) begin
      DCACHE_rdata = $urandom;
      #1;
      check("ld_addr", DCACHE_addr, 30'h40);
      check("ld_stall", MEM_stall, 1);
      tick();
      check("ld_bubble", WB_RegWrite, 0);
    end
    DCACHE_stall = 0;
    DCACHE_rdata = 32'hDEADBEEF;
    tick();
    check("ld_data", WB_data, 32'hDEADBEEF);
    check("ld_cnt", stall_cycles, 3);

    // zero-wait store
    setIns(7, 32'h8, 32'hA5A5A5A5, 0, 0, 0, 0, 1, 0);
    #1;
    check("st_wen", DCACHE_wen, 1);
    check("st_addr", DCACHE_addr, 2);
    check("st_wdata", DCACHE_wdata, 32'hA5A5A5A5);
    check("st_nostall", MEM_stall, 0);
    tick();
    check("st_we", WB_RegWrite, 0);

    // JAL
    setIns(31, 32'h777, 0, 32'h40, 1, 0, 0, 0, 1);
    tick();
    check("jal_data", WB_data, 32'h40);
    check("jal_addr", WB_addr, 31);

    // read and write together, misaligned
    setIns(2, 32'h6, 32'h55, 0, 0, 0, 1, 1, 0);
    #1;
    check("rw_ren", DCACHE_ren, 0);
    check("rw_wen", DCACHE_wen, 1);
    tick();
    clearIns();
    for (int i = 0; i < 10; i++) tick();
    check("rw_sticky", err_rw, 1);
    check("mis_sticky", err_misalign, 1);

    // reset during second stall cycle of a load
    setIns(9, 32'h200, 0, 0, 1, 1, 1, 0, 0);
    DCACHE_stall = 1;
    tick();
    rst = 1;
    tick();
    rst = 0;
    clearIns();
    check("mrst_we", WB_RegWrite, 0);
    check("mrst_data", WB_data, 0);
    check("mrst_addr", WB_addr, 0);
    check("mrst_cnt", stall_cycles, 0);
    check("mrst_err", err_rw, 0);
    tick();

    // saturation of the narrow counter
    setIns(4, 32'h300, 0, 0, 1, 1, 1, 0, 0);
    DCACHE_stall = 1;
    for (int i = 0; i < 5; i++) tick();
    check("sat_cnt2", s_cnt, 3);
    check("sat_cnt", stall_cycles, 5);
    DCACHE_stall = 0;
    DCACHE_rdata = 32'h0BADF00D;
    tick();

    // randomized instruction stream
    rst = 1; clearIns(); tick(); rst = 0;
    for (int n = 0; n < 300; n++) begin
      int kind, nStall;
      logic [31:0] alu;
      logic both;
      kind = $urandom_range(0, 3);
      alu  = $urandom;
      if ($urandom_range(0, 7) != 0) alu[1:0] = 2'b00;
      both = ($urandom_range(0, 29) == 0);
      case (kind)
        0: setIns($urandom, alu, $urandom, $urandom, $urandom, 0, 0, 0, 0);
        1: setIns($urandom, alu, $urandom, $urandom, 1, 1, 1, both, 0);
        2: setIns($urandom, alu, $urandom, $urandom, 0, 0, both, 1, 0);
        default: setIns($urandom, alu, $urandom, $urandom, 1, 0, 0, 0, 1);
      endcase
      nStall = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      if (MemRead || MemWrite) begin
        for (int s = 0; s < nStall; s++) begin
          DCACHE_stall = 1;
          DCACHE_rdata = $urandom;
          tick();
        end
        DCACHE_stall = 0;
      end else begin
        DCACHE_stall = $urandom_range(0, 1);
      end
      DCACHE_rdata = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
